dsm_bitstream_gen: RTL
======================

// Module: dsm_bitstream_gen
// PURPOSE
//  First-order delta-sigma modulator that converts unsigned IN_W-bit samples into an
//  oversampled 1-bit stream. Each sample is held for OSR clocks.
//  bit_out drives the select of the downstream 3-bit 2:1 level mux: 0 selects a, 1 selects b.
//  It has a one-deep sample buffer with a valid/ready input handshake, so the source may run ahead by one sample.
// PARAMETERS
//  IN_W  8   input sample width; ones density of bit_out = sample / 2^IN_W
//  OSR   16  clocks per input sample (oversampling ratio), >= 2
// PORTS
//  clk         in   1     single clock, all state updates on rising edge
//  rst_n       in   1     asynchronous, active-low reset
//  run_en      in   1     1 = modulate; 0 = return to IDLE
//  in_data     in   IN_W  unsigned sample
//  in_valid    in   1     in_data valid
//  in_ready    out  1     buffer slot free; transfer when in_valid & in_ready at clk edge
//  bit_out     out  1     modulator output bit (registered); to mux select
//  period_start out 1     1-cycle pulse on the first clock of each sample period
//  underrun    out  1     1-cycle pulse: period ended with no buffered next sample
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, acc=0, phase=0, cur=0, nxt_full=0,
//   bit_out=0, period_start=0, underrun=0. in_ready=1 out of reset.
//  in_ready = !nxt_full (combinational from flag only, no dependence on in_valid).
//   Accept: nxt<=in_data, nxt_full<=1.
//  State IDLE: bit_out=0, acc held at 0, phase=0.
//   Condition run_en & nxt_full -> cur<=nxt, nxt_full<=0, phase<=0, go RUN.
//   Accept and load never occur in the same cycle, because in_ready=0 while nxt_full=1.
//  State RUN, each clock:
//   sum = {1'b0,acc} + {1'b0,cur}, which is IN_W+1 bits wide.
//   bit_out<=sum[IN_W]; acc<=sum[IN_W-1:0].
//   Latency: the first bit appears one clock after the RUN entry edge.
//   The accumulator is never cleared at period boundaries; error carries across samples.
//   phase counts 0..OSR-1 and wraps to 0.
//   period_start is registered; it is high for the cycle in which phase==0 is being modulated.
//   At phase==OSR-1, next edge:
//    nxt_full=1 -> cur<=nxt, nxt_full<=0.
//    nxt_full=0 -> cur retained (repeat last sample), underrun<=1 for one cycle.
//   Simultaneous accept at the boundary edge while nxt_full=0: the new sample lands in nxt, not in cur.
//   This still counts as underrun for this period.
//   run_en=0 in RUN -> next edge: IDLE, acc<=0, phase<=0, bit_out<=0.
//    cur is discarded. nxt and nxt_full are retained.
//  Reset mid-RUN: all state is cleared immediately (async). Any buffered sample is lost.
//  Widths: phase counter is $clog2(OSR) bits. No saturation is needed because acc wraps mod 2^IN_W.
// TESTING (IN_W=8, OSR=16)
//  T1. Reset, then sample 0x80 with run_en=1.
//   -> in_ready drops for 1 cycle.
//   -> bit_out sequence 0,1,0,1,... giving 8 ones per 16 clocks.
//   -> period_start every 16 clocks.
//  T2. Samples 0x00 then 0xFF.
//   -> period 1: 16 zeros.
//   -> period 2: first bit 0, then 15 ones.
//   -> no underrun while the source keeps nxt full.
//  T3. Sample 0x40 continuously.
//   -> exactly 4 ones per 16-clock window.
//   -> ones at every 4th clock starting at clock 4.
//  T4. One sample only.
//   -> underrun pulses at each period end.
//   -> bit_out keeps the last-sample density.
//   -> late sample is picked up at the following boundary.
//  T5. Backpressure with in_valid held high and 3 samples queued.
//   -> in_ready=0 until the phase==OSR-1 edge, then 1 for exactly one cycle per period.
//   -> no sample is lost or duplicated.
//  T6. rst_n pulsed low mid-period, and separately run_en=0 mid-period.
//   -> bit_out=0 and acc=0 next cycle.
//   -> run_en case: nxt is retained and reloaded on re-enable.

Source files
------------

// File: rtl/dsm_bitstream_gen_if.sv
// Sample handshake between the source and the delta-sigma modulator.
// The source drives in_data/in_valid; the modulator answers with in_ready.
`timescale 1ns/1ps
interface dsm_bitstream_gen_if #(
   parameter int unsigned IN_W = 8
);
   logic [IN_W-1:0] in_data;
   logic            in_valid;
   logic            in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/dsm_bitstream_gen.sv
// First-order delta-sigma modulator: each unsigned sample is held for OSR clocks and
// turned into a 1-bit stream whose ones density is sample / 2^IN_W.
`timescale 1ns/1ps
module dsm_bitstream_gen #(
   parameter int unsigned IN_W = 8,
   parameter int unsigned OSR  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run_en,
   dsm_bitstream_gen_if.slave in_if,
   output logic              bit_out,
   output logic              period_start,
   output logic              underrun
);

   localparam int unsigned     PH_W    = (OSR > 2) ? $clog2(OSR) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [IN_W-1:0] acc_q, acc_d;
   logic [IN_W-1:0] cur_q, cur_d;
   logic [IN_W-1:0] nxt_q, nxt_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic            nxt_full_q, nxt_full_d;
   logic            bit_q, bit_d;
   logic            pstart_q, pstart_d;
   logic            underrun_q, underrun_d;
   logic [IN_W:0]   sum;
   logic            accept;

   // Slot-free flag alone gates the source, so a load and an accept never collide.
   assign in_if.in_ready = ~nxt_full_q;
   assign accept         = in_if.in_valid & ~nxt_full_q;
   assign sum            = {1'b0, acc_q} + {1'b0, cur_q};

   assign bit_out      = bit_q;
   assign period_start = pstart_q;
   assign underrun     = underrun_q;

   // Next-state and output decode.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cur_d      = cur_q;
      nxt_d      = nxt_q;
      phase_d    = phase_q;
      nxt_full_d = nxt_full_q;
      bit_d      = 1'b0;
      pstart_d   = 1'b0;
      underrun_d = 1'b0;

      if (accept) begin
         nxt_d      = in_if.in_data;
         nxt_full_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            acc_d   = '0;
            phase_d = '0;
            if (run_en && nxt_full_q) begin
               cur_d      = nxt_q;
               nxt_full_d = 1'b0;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            if (!run_en) begin
               state_d = S_IDLE;
               acc_d   = '0;
               phase_d = '0;
               cur_d   = '0;
            end else begin
               // Carry out of the accumulator is the output bit; residue carries across samples.
               bit_d    = sum[IN_W];
               acc_d    = sum[IN_W-1:0];
               pstart_d = (phase_q == '0);
               if (phase_q == PH_LAST) begin
                  phase_d = '0;
                  if (nxt_full_q) begin
                     cur_d      = nxt_q;
                     nxt_full_d = 1'b0;
                  end else begin
                     underrun_d = 1'b1;
                  end
               end else begin
                  phase_d = phase_q + PH_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         cur_q      <= '0;
         nxt_q      <= '0;
         phase_q    <= '0;
         nxt_full_q <= 1'b0;
         bit_q      <= 1'b0;
         pstart_q   <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cur_q      <= cur_d;
         nxt_q      <= nxt_d;
         phase_q    <= phase_d;
         nxt_full_q <= nxt_full_d;
         bit_q      <= bit_d;
         pstart_q   <= pstart_d;
         underrun_q <= underrun_d;
      end
   end

endmodule
